// File: rtl/bfp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bfp16_pkg
//  Description : Shared BFP16 (bfloat16) field widths, special encodings,
//                unpack structure and accumulator state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bfp16_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;

    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [15:0] POS_INF = 16'h7F80;
    localparam logic [15:0] NEG_INF = 16'hFF80;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } bfp16_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        OUT   = 3'd4
    } accum_state_t;

    // Unpack a raw word; a zero exponent means denormal, flushed to signed zero.
    function automatic bfp16_t unpack_ftz(input logic [15:0] v);
        bfp16_t u;
        u.sign = v[15];
        u.exp  = v[14:7];
        u.man  = (v[14:7] == '0) ? '0 : v[6:0];
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfp16_accum_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : bfp16_norm_round
//  Description : Combinational normalise and round-to-nearest-even stage.
//                Takes the raw mantissa sum (carry bit, hidden bit, mantissa,
//                guard bits with sticky folded into the LSB) and produces the
//                packed BFP16 result, including overflow to infinity and
//                underflow to signed zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module bfp16_norm_round
    import bfp16_pkg::*;
#(
    parameter int GUARD_BITS = 3
) (
    input  logic [MAN_W+1+GUARD_BITS:0] sum,
    input  logic [EXP_W-1:0]            exp,
    input  logic                        sign,
    input  logic                        zero_sign,
    output logic [15:0]                 result
);

    localparam int MW = MAN_W + 1 + GUARD_BITS;

    logic [7:0]       w_lz;
    logic [MW-1:0]    w_n;
    logic [9:0]       w_e;
    logic [9:0]       w_ef;
    logic             w_uflow;
    logic             w_guard;
    logic             w_rest;
    logic             w_rnd;
    logic [MAN_W-1:0] w_mant;
    logic [MAN_W:0]   w_m8;

    // Leading-zero count, normalise, round and classify the result.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < MW; i++) begin
            if (sum[i]) w_lz = 8'(MW - 1 - i);
        end

        if (sum[MW]) begin
            // Carry-out: one right shift, the dropped bit joins sticky.
            w_n     = {sum[MW:2], sum[1] | sum[0]};
            w_e     = {2'b00, exp} + 10'd1;
            w_uflow = 1'b0;
        end else begin
            w_n     = sum[MW-1:0] << w_lz;
            w_e     = {2'b00, exp} - {2'b00, w_lz};
            w_uflow = (exp <= w_lz);
        end

        w_mant  = w_n[MW-2:GUARD_BITS];
        w_guard = w_n[GUARD_BITS-1];
        w_rest  = |w_n[GUARD_BITS-2:0];
        w_rnd   = w_guard & (w_rest | w_mant[0]);
        w_m8    = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_rnd};
        // Rounding overflow leaves mantissa zero and bumps the exponent.
        w_ef    = w_e + {9'd0, w_m8[MAN_W]};

        if (!w_n[MW-1]) begin
            result = {zero_sign, 15'd0};
        end else if (w_uflow) begin
            result = {sign, 15'd0};
        end else if (w_ef >= 10'd255) begin
            result = sign ? NEG_INF : POS_INF;
        end else begin
            result = {sign, w_ef[7:0], w_m8[MAN_W-1:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/bfp16_accum.sv
`default_nettype none
// ============================================================================
//  Module      : bfp16_accum
//  Description : Multi-cycle BFP16 accumulator for a systolic-array PE.
//                Adds each incoming product into a running sum through the
//                ALIGN/ADD/NORM pipeline of a small FSM and emits the sum once
//                the product tagged last has been added.
//  Revision    : 1.0 - initial release
// ============================================================================
module bfp16_accum
    import bfp16_pkg::*;
#(
    parameter int GUARD_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic        acc_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    localparam int MW = MAN_W + 1 + GUARD_BITS;
    localparam logic [EXP_W-1:0] c_mw = EXP_W'(MW);

    accum_state_t     r_state;
    logic [15:0]      r_acc;
    logic [15:0]      r_op;
    logic             r_last;
    logic             r_out_valid;
    logic [15:0]      r_out_data;
    logic [MW-1:0]    r_mbig;
    logic [MW-1:0]    r_msmall;
    logic [EXP_W-1:0] r_exp;
    logic             r_sign;
    logic             r_sub;
    logic             r_zsign;
    logic             r_special;
    logic [15:0]      r_spec_val;
    logic [MW:0]      r_sum;

    bfp16_t           w_a;
    bfp16_t           w_b;
    bfp16_t           w_big;
    bfp16_t           w_lit;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_special;
    logic [15:0]      w_spec_val;
    logic [MW-1:0]    w_mbig;
    logic [MW-1:0]    w_mlit;
    logic [MW-1:0]    w_shifted;
    logic             w_sticky;
    logic [EXP_W-1:0] w_d;
    logic [15:0]      w_norm_res;

    assign in_ready  = (r_state == IDLE) && !acc_clr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Unpack, classify specials, order by magnitude and align the smaller term.
    always_comb begin
        w_a     = unpack_ftz(r_acc);
        w_b     = unpack_ftz(r_op);
        w_a_nan = (w_a.exp == '1) && (w_a.man != '0);
        w_b_nan = (w_b.exp == '1) && (w_b.man != '0);
        w_a_inf = (w_a.exp == '1) && (w_a.man == '0);
        w_b_inf = (w_b.exp == '1) && (w_b.man == '0);

        w_special  = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
        w_spec_val = QNAN;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
            w_spec_val = QNAN;
        end else if (w_a_inf) begin
            w_spec_val = w_a.sign ? NEG_INF : POS_INF;
        end else if (w_b_inf) begin
            w_spec_val = w_b.sign ? NEG_INF : POS_INF;
        end

        if ({w_b.exp, w_b.man} > {w_a.exp, w_a.man}) begin
            w_big = w_b;
            w_lit = w_a;
        end else begin
            w_big = w_a;
            w_lit = w_b;
        end

        w_mbig = (w_big.exp == '0) ? '0 : {1'b1, w_big.man, {GUARD_BITS{1'b0}}};
        w_mlit = (w_lit.exp == '0) ? '0 : {1'b1, w_lit.man, {GUARD_BITS{1'b0}}};
        w_d    = w_big.exp - w_lit.exp;

        if (w_d >= c_mw) begin
            w_shifted = '0;
            w_sticky  = |w_mlit;
        end else begin
            w_shifted = w_mlit >> w_d;
            w_sticky  = |(w_mlit & ~({MW{1'b1}} << w_d));
        end
    end

    bfp16_norm_round #(
        .GUARD_BITS (GUARD_BITS)
    ) u_norm_round (
        .sum        (r_sum),
        .exp        (r_exp),
        .sign       (r_sign),
        .zero_sign  (r_zsign),
        .result     (w_norm_res)
    );

    // Accumulator FSM: capture, align, add, normalise/commit, present result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= 16'h0000;
            r_op        <= 16'h0000;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_mbig      <= '0;
            r_msmall    <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_zsign     <= 1'b0;
            r_special   <= 1'b0;
            r_spec_val  <= 16'h0000;
            r_sum       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (acc_clr) begin
                        r_acc <= 16'h0000;
                    end else if (in_valid) begin
                        r_op    <= in_data;
                        r_last  <= in_last;
                        r_state <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_mbig     <= w_mbig;
                    r_msmall   <= {w_shifted[MW-1:1], w_shifted[0] | w_sticky};
                    r_exp      <= w_big.exp;
                    r_sign     <= w_big.sign;
                    r_sub      <= w_a.sign ^ w_b.sign;
                    r_zsign    <= (w_a.exp == '0) && (w_b.exp == '0) && w_a.sign && w_b.sign;
                    r_special  <= w_special;
                    r_spec_val <= w_spec_val;
                    r_state    <= ADD;
                end
                ADD: begin
                    r_sum   <= r_sub ? ({1'b0, r_mbig} - {1'b0, r_msmall})
                                     : ({1'b0, r_mbig} + {1'b0, r_msmall});
                    r_state <= NORM;
                end
                NORM: begin
                    r_acc <= r_special ? r_spec_val : w_norm_res;
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_special ? r_spec_val : w_norm_res;
                        r_state     <= OUT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= 16'h0000;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bfp16_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bfp16_accum
//  Description : Self-checking bench for bfp16_accum: table of two-term dot
//                products plus hand sequences for timing, backpressure,
//                clear and reset corner cases. Results flow through a
//                scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bfp16_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[15];

    bfp16_accum #(.GUARD_BITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endfunction

    // Scoreboard: every completed output handshake pops one expected sum.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got=%h want=none", out_data);
            end else begin
                check("out_data", out_data, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout_in_ready", {15'd0, in_ready}, 16'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("result_timeout", 16'(sb.size()), 16'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int busy;
        int n;

        vecs[0]  = '{16'h4000, 16'h4040, 16'h40A0};
        vecs[1]  = '{16'h40C0, 16'h3F80, 16'h40E0};
        vecs[2]  = '{16'h3F80, 16'h3B80, 16'h3F80};
        vecs[3]  = '{16'h3F81, 16'h3B80, 16'h3F82};
        vecs[4]  = '{16'h3F80, 16'h3BC0, 16'h3F81};
        vecs[5]  = '{16'h7F80, 16'hFF80, 16'h7FC0};
        vecs[6]  = '{16'h7F7F, 16'h7F7F, 16'h7F80};
        vecs[7]  = '{16'h4040, 16'hC040, 16'h0000};
        vecs[8]  = '{16'h7FC1, 16'h4000, 16'h7FC0};
        vecs[9]  = '{16'h0001, 16'h0001, 16'h0000};
        vecs[10] = '{16'hC000, 16'h3F80, 16'hBF80};
        vecs[11] = '{16'h3F80, 16'hBF00, 16'h3F00};
        vecs[12] = '{16'h7F80, 16'h4000, 16'h7F80};
        vecs[13] = '{16'h3F80, 16'h3380, 16'h3F80};
        vecs[14] = '{16'h0081, 16'h8080, 16'h0000};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {15'd0, in_ready}, 16'd1);
        check("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check("reset_out_data", out_data, 16'h0000);

        // Pair sum with in_ready busy window and output latency.
        sb.push_back(16'h40A0);
        send(16'h4000, 1'b0);
        busy = 0;
        while (!in_ready && busy < 10) begin
            busy++;
            @(negedge clk);
        end
        check("busy_cycles", 16'(busy), 16'd3);
        send(16'h4040, 1'b1);
        repeat (3) @(negedge clk);
        check("latency_out_valid", {15'd0, out_valid}, 16'd1);
        check("out_in_ready", {15'd0, in_ready}, 16'd0);
        wait_sb_empty();

        // Table of two-term sums, each starting from +0.
        for (int i = 0; i < 15; i++) begin
            sb.push_back(vecs[i].exp);
            send(vecs[i].a, 1'b0);
            send(vecs[i].b, 1'b1);
            wait_sb_empty();
        end

        // Backpressure: output held stable while out_ready is low.
        out_ready = 1'b0;
        sb.push_back(16'h40E0);
        send(16'h40C0, 1'b0);
        send(16'h3F80, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {15'd0, out_valid}, 16'd1);
            check("bp_out_data", out_data, 16'h40E0);
            check("bp_in_ready", {15'd0, in_ready}, 16'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_sb_empty();
        sb.push_back(16'h3F80);
        send(16'h3F80, 1'b1);
        wait_sb_empty();

        // acc_clr wins over in_valid in the same IDLE cycle.
        sb.push_back(16'h3F80);
        send(16'h4000, 1'b0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc_clr = 1'b1; in_valid = 1'b1; in_data = 16'h4040; in_last = 1'b1;
        #1;
        check("clr_in_ready", {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        acc_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        check("clr_idle_in_ready", {15'd0, in_ready}, 16'd1);
        send(16'h3F80, 1'b1);
        wait_sb_empty();

        // Reset during ADD aborts the addition and clears the accumulator.
        send(16'h4000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        sb.push_back(16'h3F80);
        send(16'h3F80, 1'b1);
        wait_sb_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
